regfile_wb_arbiter: RTL and testbench

Writeback arbiter and scoreboard in front of the single-write-port register file. Up to NUM_SRC writeback sources (ALU, load unit, CSR/mul) compete for the one write port through valid/ready handshakes. A round-robin grant drives a registered write port. A 31-entry busy scoreboard tells decode whether rs1/rs2 have a pending producer and whether a new destination may be issued.

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter with a registered register-file write port and a busy scoreboard.
// Round-robin grants one writeback per cycle; the scoreboard tracks pending producers.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC-1:0][4:0]  src_addr_i,
  input  logic [NUM_SRC-1:0][31:0] src_data_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
  input  logic                     issue_valid_i,
  input  logic [4:0]               issue_addr_i,
  output logic                     issue_ready_o,
  input  logic [4:0]               rs1_addr_i,
  input  logic [4:0]               rs2_addr_i,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  output logic [31:0]              rd_d_o,
  output logic [4:0]               rd_addr_o,
  output logic                     we_o
);

  localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] bus32_t;

  logic [PtrW-1:0] r_ptr;
  logic            r_we;
  reg_addr_t       r_rd_addr;
  bus32_t          r_rd_data;
  logic [31:0]     r_busy;

  logic [PtrW:0]      w_cand;
  logic [PtrW-1:0]    w_win;
  logic               w_found;
  logic [NUM_SRC-1:0] w_grant;
  logic [PtrW-1:0]    w_ptr_next;
  logic               w_issue_set;
  logic [31:0]        w_busy_d;

  // Scan from the priority pointer; first valid source wins.
  always_comb begin
    w_cand  = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_cand = {1'b0, r_ptr} + (PtrW+1)'(i);
      if (w_cand >= (PtrW+1)'(NUM_SRC)) begin
        w_cand = w_cand - (PtrW+1)'(NUM_SRC);
      end
      if (!w_found && src_valid_i[w_cand[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PtrW-1:0];
      end
    end
    if (w_found) begin
      w_grant[w_win] = 1'b1;
    end
  end

  assign src_ready_o = w_grant;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_found) begin
      if ({1'b0, w_win} == (PtrW+1)'(NUM_SRC - 1)) begin
        w_ptr_next = '0;
      end else begin
        w_ptr_next = w_win + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr     <= '0;
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      if (w_found) begin
        r_we      <= (src_addr_i[w_win] != 5'd0);
        r_rd_addr <= src_addr_i[w_win];
        r_rd_data <= src_data_i[w_win];
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign we_o      = r_we;
  assign rd_addr_o = r_rd_addr;
  assign rd_d_o    = r_rd_data;

  // Bit 0 is held at zero, so x0 always reads as free.
  assign issue_ready_o = ~r_busy[issue_addr_i];
  assign rs1_busy_o    = r_busy[rs1_addr_i];
  assign rs2_busy_o    = r_busy[rs2_addr_i];

  assign w_issue_set = issue_valid_i & issue_ready_o & (issue_addr_i != 5'd0);

  // Clear on the actual register-file write; a same-cycle set overrides it.
  always_comb begin
    w_busy_d = r_busy;
    if (r_we) begin
      w_busy_d[r_rd_addr] = 1'b0;
    end
    if (w_issue_set) begin
      w_busy_d[issue_addr_i] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model plus a scoreboard queue of
// expected write-port values, one entry per clock edge.
module tb_regfile_wb_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      src_valid;
  logic [2:0][4:0] src_addr;
  logic [2:0][31:0] src_data;
  logic [2:0]      src_ready;
  logic            issue_valid;
  logic [4:0]      issue_addr;
  logic            issue_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [31:0]     rd_d;
  logic [4:0]      rd_addr;
  logic            we;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  regfile_wb_arbiter #(
    .NUM_SRC(3)
  ) u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .src_valid_i  (src_valid),
    .src_addr_i   (src_addr),
    .src_data_i   (src_data),
    .src_ready_o  (src_ready),
    .issue_valid_i(issue_valid),
    .issue_addr_i (issue_addr),
    .issue_ready_o(issue_ready),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy),
    .rd_d_o       (rd_d),
    .rd_addr_o    (rd_addr),
    .we_o         (we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next one.
  task automatic tick(input string tag);
    wb_exp_t     e;
    wb_exp_t     n;
    int          g;
    int          idx;
    logic [2:0]  exp_ready;
    logic        exp_iready;
    logic [31:0] nb;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard underflow", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".we"}, 64'(we), 64'(e.we));
      check({tag, ".rd_addr"}, 64'(rd_addr), 64'(e.addr));
      check({tag, ".rd_d"}, 64'(rd_d), 64'(e.data));
    end
    g = -1;
    for (int i = 0; i < 3; i++) begin
      idx = (m_ptr + i) % 3;
      if (g < 0 && src_valid[idx]) g = idx;
    end
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    exp_iready = (issue_addr == 5'd0) ? 1'b1 : !m_busy[issue_addr];
    check({tag, ".src_ready"}, 64'(src_ready), 64'(exp_ready));
    check({tag, ".issue_ready"}, 64'(issue_ready), 64'(exp_iready));
    check({tag, ".rs1_busy"}, 64'(rs1_busy), 64'((rs1_addr != 0) && m_busy[rs1_addr]));
    check({tag, ".rs2_busy"}, 64'(rs2_busy), 64'((rs2_addr != 0) && m_busy[rs2_addr]));
    nb = m_busy;
    if (m_we) nb[m_addr] = 1'b0;
    if (issue_valid && exp_iready && issue_addr != 5'd0) nb[issue_addr] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    if (g >= 0) begin
      m_we   = (src_addr[g] != 5'd0);
      m_addr = src_addr[g];
      m_data = src_data[g];
      m_ptr  = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
    n.we = m_we;
    n.addr = m_addr;
    n.data = m_data;
    sb_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous clear immediately.
  task automatic do_reset();
    wb_exp_t r;
    src_valid   = '0;
    issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.we", 64'(we), 64'(0));
    check("rst.rd_addr", 64'(rd_addr), 64'(0));
    check("rst.rd_d", 64'(rd_d), 64'(0));
    check("rst.src_ready", 64'(src_ready), 64'(0));
    check("rst.issue_ready", 64'(issue_ready), 64'(1));
    check("rst.rs1_busy", 64'(rs1_busy), 64'(0));
    m_ptr = 0;
    m_busy = '0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    sb_q.delete();
    r.we = 1'b0;
    r.addr = '0;
    r.data = '0;
    sb_q.push_back(r);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    src_valid   = '0;
    src_addr    = '0;
    src_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    rs1_addr    = 5'd5;
    rs2_addr    = 5'd0;
    @(posedge clk);
    #1;
    do_reset();
    tick("idle");

    // Single write x5 = DEADBEEF from source 0.
    src_valid = 3'b001;
    src_addr[0] = 5'd5;
    src_data[0] = 32'hDEADBEEF;
    tick("wr5_acc");
    src_valid = '0;
    tick("wr5_we");
    tick("wr5_idle");

    // All three sources continuously valid: grants rotate 0,1,2,0,1,2.
    do_reset();
    src_addr[0] = 5'd1; src_data[0] = 32'h1111_0001;
    src_addr[1] = 5'd2; src_data[1] = 32'h2222_0002;
    src_addr[2] = 5'd3; src_data[2] = 32'h3333_0003;
    src_valid = 3'b111;
    for (int i = 0; i < 6; i++) tick($sformatf("rr%0d", i));
    src_valid = '0;
    tick("rr_drain");
    tick("rr_idle");

    // Scoreboard: reserve x7, write it back from source 1, re-issue blocked until clear.
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    rs1_addr    = 5'd7;
    rs2_addr    = 5'd7;
    tick("iss7");
    tick("iss7_blocked");
    src_valid = 3'b010;
    src_addr[1] = 5'd7;
    src_data[1] = 32'h12;
    tick("wb7_acc");
    src_valid = '0;
    tick("wb7_we");
    tick("wb7_clear");
    issue_valid = 1'b0;
    tick("wb7_idle");

    // Writeback to x0 is accepted but never writes; issue to x0 is always ready.
    src_valid = 3'b001;
    src_addr[0] = 5'd0;
    src_data[0] = 32'hFFFF_FFFF;
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    rs1_addr    = 5'd0;
    tick("x0_acc");
    src_valid = '0;
    tick("x0_nowe");
    issue_valid = 1'b0;
    tick("x0_idle");

    // Source 2 alone from ptr 0, then sources 0 and 2 together: source 0 wins.
    do_reset();
    src_valid = 3'b100;
    src_addr[2] = 5'd4; src_data[2] = 32'hA5A5_0004;
    tick("s2_alone");
    src_valid = 3'b101;
    src_addr[0] = 5'd6; src_data[0] = 32'h5A5A_0006;
    tick("s0s2_a");
    src_valid = 3'b100;
    tick("s0s2_b");
    src_valid = '0;
    tick("s0s2_drain");

    // Reset between acceptance and the write: write dropped, busy cleared, ptr back to 0.
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    rs1_addr    = 5'd9;
    tick("iss9");
    issue_valid = 1'b0;
    src_valid = 3'b010;
    src_addr[1] = 5'd9;
    src_data[1] = 32'h0909_0909;
    tick("wb9_acc");
    issue_addr = 5'd9;
    do_reset();
    tick("post_rst_idle");
    src_valid = 3'b111;
    tick("post_rst_all");
    src_valid = '0;
    tick("post_rst_drain");
    tick("post_rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
